// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: word/byte widths,
// loader FSM states and the word-index to byte-address mapping.
package imem_pkg;

  localparam int IMEM_WORD_W = 32;
  localparam int IMEM_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

  // Instruction memory indexes words with A[31:2], so word n lives at base + 4n.
  function automatic logic [IMEM_WORD_W-1:0] word_to_byte_addr(
    input logic [IMEM_WORD_W-1:0] idx,
    input logic [IMEM_WORD_W-1:0] base
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: inbound byte stream (valid/ready/last) plus the outbound
// instruction-memory write port. The loader uses the slave view.
interface imem_loader_if;
  import imem_pkg::*;

  logic                   in_valid;
  logic [IMEM_BYTE_W-1:0] in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   mem_we;
  logic [IMEM_WORD_W-1:0] mem_addr;
  logic [IMEM_WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer. Holds the byte lane counter and the
// word under assembly; flags when a byte completes the word (4th byte) or
// ends it early (last byte of the image on a partial word).
module byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   acc,
  input  logic [IMEM_BYTE_W-1:0] data,
  input  logic                   last,
  output logic [IMEM_WORD_W-1:0] word,
  output logic                   word_full,
  output logic                   part_last
);

  logic [1:0] byte_idx;

  assign word_full = acc && (byte_idx == 2'd3);
  assign part_last = acc && last && (byte_idx != 2'd3);

  // Insert accepted bytes into their lane; a clear zeroes the word so
  // unfilled upper lanes of a short final word read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      word     <= '0;
    end else if (clr) begin
      byte_idx <= 2'd0;
      word     <= '0;
    end else if (acc) begin
      word[{byte_idx, 3'b000} +: IMEM_BYTE_W] <= data;
      byte_idx <= (word_full || part_last) ? 2'd0 : byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into 32-bit words,
// writes them to consecutive word addresses from BASE_ADDR and holds the
// core until the image (in_last or DEPTH words) is complete.
// Optional: define IMEM_LOADER_CHECKSUM_EN to add a running mod-2^32 sum
// of the written words on the checksum output.
module imem_loader
  import imem_pkg::*;
#(
  parameter int               DEPTH     = 64,
  parameter logic [31:0]      BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  imem_loader_if.slave           bus,
  output logic                   cpu_hold,
  output logic                   done,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [IMEM_WORD_W-1:0] checksum,
`endif
  output logic [$clog2(DEPTH):0] words_loaded
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  ld_state_e              state;
  logic [CW-1:0]          word_idx;
  logic                   last_q;
  logic                   mem_we_q;
  logic [IMEM_WORD_W-1:0] mem_addr_q;
  logic [IMEM_WORD_W-1:0] word;
  logic                   acc;
  logic                   word_full;
  logic                   part_last;
  logic                   word_end;
  logic                   load_end;
  logic                   pk_clr;

  assign bus.in_ready  = (state == RECV);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = word;

  assign acc      = bus.in_valid && bus.in_ready;
  assign word_end = word_full || part_last;
  assign load_end = last_q || (word_idx == LAST_IDX);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .acc       (acc),
    .data      (bus.in_data),
    .last      (bus.in_last),
    .word      (word),
    .word_full (word_full),
    .part_last (part_last)
  );

  // Packer is wiped on a new load and after each write that continues the load;
  // on the final write the word is left intact for inspection.
  always_comb begin
    pk_clr = 1'b0;
    case (state)
      IDLE, DONE: pk_clr = start;
      WRITE:      pk_clr = !load_end;
      default:    pk_clr = 1'b0;
    endcase
  end

  // Load sequencer: receive bytes, issue one write strobe per word, finish on
  // in_last or after the last memory word, hold the core until finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_idx     <= '0;
      words_loaded <= '0;
      last_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RECV;
            word_idx     <= '0;
            words_loaded <= '0;
            last_q       <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
          end
        end
        RECV: begin
          if (word_end) begin
            state      <= WRITE;
            last_q     <= bus.in_last;
            mem_we_q   <= 1'b1;
            mem_addr_q <= word_to_byte_addr(32'(word_idx), BASE_ADDR);
          end
        end
        WRITE: begin
          mem_we_q     <= 1'b0;
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum     <= checksum + word;
`endif
          if (load_end) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state    <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (DEPTH=4 so the word limit is
// reachable). Expected writes are queued by a reference model when a load
// is issued; a monitor pops and compares on every mem_we.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done;
  logic [$clog2(DEPTH):0] words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int exp_words;
  int exp_acc;
  logic [31:0] exp_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", bus.mem_addr, e[63:32]);
        chk("write_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  // Reference: image is cut at DEPTH words; words are little-endian groups of
  // four bytes, a short tail is zero-padded.
  task automatic model(input logic [7:0] b[$]);
    int n;
    n = b.size();
    exp_acc = (n < 4 * DEPTH) ? n : 4 * DEPTH;
    exp_words = (exp_acc + 3) / 4;
    exp_sum = '0;
    for (int k = 0; k < exp_words; k++) begin
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < exp_acc) w = w | (32'(b[4 * k + j]) << (8 * j));
      exp_q.push_back({BASE + 32'(4 * k), w});
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Drive bytes with optional random gaps; gaps toggle in_last with
  // in_valid low and may pulse start, both of which must be ignored.
  task automatic send(input logic [7:0] b[$], input bit has_last, input bit gaps, output int accepted);
    int idx, cyc;
    idx = 0; cyc = 0;
    while (idx < b.size() && !done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
        if ($urandom_range(0, 3) == 0) start = 1'b1;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b[idx];
        bus.in_last  = has_last && (idx == b.size() - 1);
        if (bus.in_ready) idx++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; start = 1'b0;
    accepted = idx;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic load(input string tag, input logic [7:0] b[$], input bit has_last, input bit gaps);
    int acc;
    pulse_start();
    chk({tag, "_hold_during"}, 32'(cpu_hold), 32'd1);
    model(b);
    send(b, has_last, gaps, acc);
    wait_done();
    repeat (2) @(negedge clk);
    chk({tag, "_accepted"}, 32'(acc), 32'(exp_acc));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, exp_sum);
`endif
  endtask

  initial begin
    logic [7:0] b[$];
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;

    // Reset and idle without start
    #12;
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_addr", bus.mem_addr, BASE);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_hold", 32'(cpu_hold), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
      chk("idle_we", 32'(bus.mem_we), 32'd0);
      chk("idle_words", 32'(words_loaded), 32'd0);
    end

    // Single full word ending with in_last
    b = '{8'h03, 8'hA3, 8'hC4, 8'hFF};
    load("one_word", b, 1'b1, 1'b0);
    chk("one_word_value", exp_sum, 32'hFFC4A303);

    // Two words with random gaps and stray starts
    b = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA6, 8'h64, 8'h00};
    load("two_words", b, 1'b1, 1'b1);

    // Partial final word
    b = '{8'h33, 8'hE2};
    load("partial", b, 1'b1, 1'b0);
    chk("partial_value", exp_sum, 32'h0000E233);

    // DEPTH boundary: 20 bytes, no in_last
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    load("depth", b, 1'b0, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      chk("depth_backpressure", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Reset mid-load after two bytes of word 1
    pulse_start();
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    @(negedge clk); bus.in_data = 8'h22;
    @(negedge clk); bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(exp_q.size()), 32'd0);
    b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20};
    load("reload", b, 1'b1, 1'b1);

    // Checksum wrap: 1 + FFFFFFFF
    b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load("wrap", b, 1'b1, 1'b0);
    chk("wrap_sum_model", exp_sum, 32'h0);

    // Random images
    for (int t = 0; t < 8; t++) begin
      int n;
      bit hl;
      n = $urandom_range(1, 20);
      hl = (n < 16) ? 1'b1 : ((n == 16) ? 1'($urandom_range(0, 1)) : 1'b0);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      load("rand", b, hl, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
